sw_job_arbiter: RTL and testbench

//  Round-robin scheduler that shares one SW_core between NUM_REQ job sources (e.g. UART wrappers).
//  - Accepts one alignment job at a time and range-checks its lengths.
//  - Launches SW_core over its valid/ready handshake and routes the result to the originating requester.
//  - Watchdog flags and drains a core run that takes longer than TIMEOUT_CYCLES.

---
 rtl/sw_job_arbiter.sv | 129 ++++++++++++
 tb/tb_sw_job_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_job_arbiter.sv
// sw_job_arbiter: round-robin sharing of one SW_core between NUM_REQ job sources with length checks and a watchdog
module sw_job_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REF_MAX_LENGTH = 128,
  parameter int READ_MAX_LENGTH = 128,
  parameter int SCORE_BW = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int LR = $clog2(REF_MAX_LENGTH),
  localparam int LQ = $clog2(READ_MAX_LENGTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*2*REF_MAX_LENGTH-1:0]  req_ref,
  input  logic [NUM_REQ*2*READ_MAX_LENGTH-1:0] req_read,
  input  logic [NUM_REQ*(LR+1)-1:0]         req_ref_len,
  input  logic [NUM_REQ*(LQ+1)-1:0]         req_read_len,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [SCORE_BW-1:0]               rsp_score,
  output logic [LR-1:0]                     rsp_column,
  output logic [LQ-1:0]                     rsp_row,
  output logic [1:0]                        rsp_error,
  output logic                              core_in_valid,
  input  logic                              core_in_ready,
  output logic [2*REF_MAX_LENGTH-1:0]       core_ref,
  output logic [2*READ_MAX_LENGTH-1:0]      core_read,
  output logic [LR:0]                       core_ref_len,
  output logic [LQ:0]                       core_read_len,
  input  logic                              core_out_valid,
  output logic                              core_out_ready,
  input  logic [SCORE_BW-1:0]               core_score,
  input  logic [LR-1:0]                     core_column,
  input  logic [LQ-1:0]                     core_row,
  output logic                              busy
);
  localparam int RB = 2*REF_MAX_LENGTH;
  localparam int QB = 2*READ_MAX_LENGTH;
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [LR:0] REF_MAX = (LR+1)'(REF_MAX_LENGTH);
  localparam logic [LQ:0] READ_MAX = (LQ+1)'(READ_MAX_LENGTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES-1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP, S_DRAIN} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, owner, grant;
  logic [PW:0] cand;
  logic [TW-1:0] timer;
  logic any_req, accept, bad_len, timed_out;
  logic [LR:0] sel_ref_len;
  logic [LQ:0] sel_read_len;
  // Walk the requesters starting at rr_ptr; iterating backwards leaves the first hit in grant.
  always_comb begin
    grant = '0;
    any_req = 1'b0;
    cand = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      cand = (cand >= (PW+1)'(NUM_REQ)) ? cand - (PW+1)'(NUM_REQ) : cand;
      if (req_valid[cand[PW-1:0]]) begin
        grant = cand[PW-1:0];
        any_req = 1'b1;
      end
    end
  end
  assign sel_ref_len = req_ref_len[grant*(LR+1) +: LR+1];
  assign sel_read_len = req_read_len[grant*(LQ+1) +: LQ+1];
  assign bad_len = sel_ref_len == '0 || sel_ref_len > REF_MAX || sel_read_len == '0 || sel_read_len > READ_MAX;
  assign accept = state == S_IDLE && any_req;
  assign timed_out = timer == TIMER_LAST;
  assign req_ready = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant : '0;
  assign rsp_valid = state == S_RESP ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner : '0;
  assign core_in_valid = state == S_ISSUE;
  assign core_out_ready = state == S_BUSY || state == S_DRAIN;
  assign busy = state != S_IDLE;
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = !any_req ? S_IDLE : bad_len ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = core_in_ready ? S_BUSY : S_ISSUE;
      S_BUSY:  state_nx = (core_out_valid || timed_out) ? S_RESP : S_BUSY;
      S_RESP:  state_nx = !rsp_ready[owner] ? S_RESP : rsp_error == 2'b10 ? S_DRAIN : S_IDLE;
      S_DRAIN: state_nx = core_out_valid ? S_IDLE : S_DRAIN;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      owner <= '0;
      timer <= '0;
      core_ref <= '0;
      core_read <= '0;
      core_ref_len <= '0;
      core_read_len <= '0;
      rsp_score <= '0;
      rsp_column <= '0;
      rsp_row <= '0;
      rsp_error <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= grant;
        rr_ptr <= (grant == PW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        core_ref <= req_ref[grant*RB +: RB];
        core_read <= req_read[grant*QB +: QB];
        core_ref_len <= sel_ref_len;
        core_read_len <= sel_read_len;
        rsp_score <= '0;
        rsp_column <= '0;
        rsp_row <= '0;
        rsp_error <= bad_len ? 2'b01 : 2'b00;
      end
      if (state == S_ISSUE && core_in_ready) timer <= '0;
      // A result arriving in the final watchdog cycle takes priority over the timeout.
      if (state == S_BUSY) begin
        timer <= timer + 1'b1;
        if (core_out_valid) begin
          rsp_score <= core_score;
          rsp_column <= core_column;
          rsp_row <= core_row;
          rsp_error <= 2'b00;
        end else if (timed_out) rsp_error <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_sw_job_arbiter.sv
// tb_sw_job_arbiter: scoreboard bench for sw_job_arbiter with a behavioural SW_core responder
module tb_sw_job_arbiter;
  localparam int NR = 2;
  localparam int RM = 128;
  localparam int QM = 128;
  localparam int SB = 10;
  localparam int TO = 16;
  localparam int LR = $clog2(RM);
  localparam int LQ = $clog2(QM);
  typedef struct packed {
    logic [NR-1:0] own;
    logic [SB-1:0] sc;
    logic [LR-1:0] col;
    logic [LQ-1:0] row;
    logic [1:0]    err;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*2*RM-1:0] req_ref;
  logic [NR*2*QM-1:0] req_read;
  logic [NR*(LR+1)-1:0] req_ref_len;
  logic [NR*(LQ+1)-1:0] req_read_len;
  logic [SB-1:0] rsp_score, core_score;
  logic [LR-1:0] rsp_column, core_column;
  logic [LQ-1:0] rsp_row, core_row;
  logic [1:0] rsp_error;
  logic core_in_valid, core_in_ready, core_out_valid, core_out_ready, busy;
  logic [2*RM-1:0] core_ref;
  logic [2*QM-1:0] core_read;
  logic [LR:0] core_ref_len;
  logic [LQ:0] core_read_len;
  int errors = 0;
  int checks = 0;
  rsp_t sb_q[$];
  int cyc = 0, t_in = 0, t_rsp = 0, n_in = 0, n_out = 0, n_civ = 0, n_rv = 0, n_rsp = 0;
  int core_lat = 4, in_stall = 0, rsp_hold = 0, cnt = -1, g = 0;
  bit fix_en = 1'b0, in_fire = 1'b0, out_fire = 1'b0;
  logic [SB-1:0] fix_sc = '0, pend_sc = '0;
  logic [LR-1:0] fix_col = '0, pend_col = '0;
  logic [LQ-1:0] fix_row = '0, pend_row = '0;
  logic [LR:0] exp_rl = '0;
  logic [LQ:0] exp_ql = '0;
  logic [63:0] exp_ref = '0;
  logic [NR-1:0] prev_rv = '0;

  sw_job_arbiter #(.NUM_REQ(NR), .REF_MAX_LENGTH(RM), .READ_MAX_LENGTH(QM), .SCORE_BW(SB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ref(req_ref), .req_read(req_read),
    .req_ref_len(req_ref_len), .req_read_len(req_read_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_score(rsp_score), .rsp_column(rsp_column),
    .rsp_row(rsp_row), .rsp_error(rsp_error),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_ref(core_ref), .core_read(core_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_score(core_score),
    .core_column(core_column), .core_row(core_row), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t good(input int r, input logic [LR:0] rl, input logic [LQ:0] ql);
    rsp_t e;
    e.own = NR'(1) << r;
    e.sc = SB'(rl) + SB'(ql);
    e.col = rl[LR-1:0] ^ LR'('h55);
    e.row = ql[LQ-1:0];
    e.err = 2'b00;
    return e;
  endfunction

  function automatic rsp_t bad(input int r, input logic [1:0] err);
    rsp_t e;
    e = '0;
    e.own = NR'(1) << r;
    e.err = err;
    return e;
  endfunction

  // SW_core responder plus output monitor, all evaluated on the falling edge
  initial begin
    core_in_ready = 1'b0;
    core_out_valid = 1'b0;
    core_score = '0;
    core_column = '0;
    core_row = '0;
    rsp_ready = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        cnt = -1;
        in_fire = 1'b0;
        out_fire = 1'b0;
        core_out_valid = 1'b0;
        core_in_ready = 1'b0;
        rsp_ready = '1;
      end else begin
        if (out_fire) core_out_valid = 1'b0;
        if (in_fire) begin
          cnt = core_lat;
          pend_sc = fix_en ? fix_sc : SB'(core_ref_len) + SB'(core_read_len);
          pend_col = fix_en ? fix_col : core_ref_len[LR-1:0] ^ LR'('h55);
          pend_row = fix_en ? fix_row : core_read_len[LQ-1:0];
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_out_valid = 1'b1;
            core_score = pend_sc;
            core_column = pend_col;
            core_row = pend_row;
          end
        end
        core_in_ready = !(core_in_valid && in_stall > 0);
        if (!core_in_ready) in_stall--;
        in_fire = core_in_valid && core_in_ready;
        out_fire = core_out_valid && core_out_ready;
        if (core_in_valid) n_civ++;
        if (in_fire) begin
          n_in++;
          t_in = cyc;
        end
        if (out_fire) n_out++;
        check("req_ready_onehot", 64'($onehot0(req_ready)), 64'(1));
        if (req_ready != '0) begin
          g = req_ready[1] ? 1 : 0;
          exp_rl = req_ref_len[g*(LR+1) +: LR+1];
          exp_ql = req_read_len[g*(LQ+1) +: LQ+1];
          exp_ref = req_ref[g*2*RM +: 64];
        end
        if (core_in_valid) begin
          check("core_ref_len", 64'(core_ref_len), 64'(exp_rl));
          check("core_read_len", 64'(core_read_len), 64'(exp_ql));
          check("core_ref", core_ref[63:0], exp_ref);
        end
        if (rsp_valid != '0) begin
          n_rv++;
          if (prev_rv == '0) t_rsp = cyc;
          if (sb_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'(0));
          else begin
            check("rsp_valid", 64'(rsp_valid), 64'(sb_q[0].own));
            check("rsp_score", 64'(rsp_score), 64'(sb_q[0].sc));
            check("rsp_column", 64'(rsp_column), 64'(sb_q[0].col));
            check("rsp_row", 64'(rsp_row), 64'(sb_q[0].row));
            check("rsp_error", 64'(rsp_error), 64'(sb_q[0].err));
          end
          rsp_ready = (rsp_hold > 0) ? ~rsp_valid : '1;
          if (rsp_hold > 0) rsp_hold--;
          if ((rsp_valid & rsp_ready) != '0 && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
            n_rsp++;
          end
        end else rsp_ready = '1;
        prev_rv = rsp_valid;
      end
    end
  end

  task automatic load(input int r, input logic [LR:0] rl, input logic [LQ:0] ql);
    req_ref_len[r*(LR+1) +: LR+1] = rl;
    req_read_len[r*(LQ+1) +: LQ+1] = ql;
    req_ref[r*2*RM +: 2*RM] = {8{32'($urandom())}};
    req_read[r*2*QM +: 2*QM] = {8{32'($urandom())}};
  endtask

  task automatic wait_req(input logic [NR-1:0] m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((req_ready & m) == '0 && n < 100);
    if (n >= 100) check("accept_timeout", 64'(req_ready & m), 64'(m));
  endtask

  task automatic job(input int r, input logic [LR:0] rl, input logic [LQ:0] ql, input rsp_t e);
    @(posedge clk);
    #1;
    load(r, rl, ql);
    sb_q.push_back(e);
    req_valid[r] = 1'b1;
    wait_req(NR'(1) << r);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic settle(input int lim);
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) check("idle_timeout", 64'(busy || sb_q.size() != 0), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_civ, b_in, b_out, b_rv, b_rsp, gi;
    int gc[NR];
    logic [LR:0] rl;
    logic [LQ:0] ql;
    req_valid = '0;
    req_ref = '0;
    req_read = '0;
    req_ref_len = '0;
    req_read_len = '0;
    gc = '{default: 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_core_in_valid", 64'(core_in_valid), 64'(0));
    check("rst_core_out_ready", 64'(core_out_ready), 64'(0));
    check("rst_rsp_error", 64'(rsp_error), 64'(0));
    check("rst_core_ref_len", 64'(core_ref_len), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    // single job at maximum lengths with a fixed core answer
    fix_en = 1'b1;
    fix_sc = SB'(42);
    fix_col = LR'(5);
    fix_row = LQ'(7);
    core_lat = 12;
    job(0, 8'd128, 8'd128, '{own: 2'b01, sc: 10'd42, col: 7'd5, row: 7'd7, err: 2'b00});
    @(negedge clk);
    check("t1_issue_next_cycle", 64'(core_in_valid), 64'(1));
    settle(200);
    check("t1_latency", 64'(t_rsp - t_in), 64'(core_lat + 2));
    fix_en = 1'b0;
    // result arrives in the last watchdog cycle: result wins; minimum lengths
    core_lat = TO - 1;
    job(1, 8'd1, 8'd1, good(1, 8'd1, 8'd1));
    settle(200);
    check("t1b_result_wins_lat", 64'(t_rsp - t_in), 64'(TO + 1));
    // contention: both requesters held valid for three jobs each
    core_lat = 3;
    @(posedge clk);
    #1;
    load(0, 8'd10, 8'd20);
    load(1, 8'd30, 8'd40);
    for (int k = 0; k < 6; k++) begin
      rl = (k % 2 == 1) ? 8'd30 : 8'd10;
      ql = (k % 2 == 1) ? 8'd40 : 8'd20;
      sb_q.push_back(good(k % 2, rl, ql));
    end
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      wait_req('1);
      gi = req_ready[1] ? 1 : 0;
      check("t2_grant_order", 64'(gi), 64'(k % 2));
      gc[gi]++;
      @(posedge clk);
      #1;
      if (gc[gi] == 3) req_valid[gi] = 1'b0;
    end
    settle(300);
    // bad lengths never reach the core
    b_civ = n_civ;
    b_in = n_in;
    job(1, 8'd0, 8'd50, bad(1, 2'b01));
    settle(100);
    check("t3_no_issue", 64'(n_civ - b_civ), 64'(0));
    job(0, 8'd60, 8'd129, bad(0, 2'b01));
    settle(100);
    check("t4_no_issue", 64'(n_civ - b_civ), 64'(0));
    check("t4_no_core_xfer", 64'(n_in - b_in), 64'(0));
    // timeout, then the late core result is drained and swallowed
    core_lat = 25;
    b_out = n_out;
    job(1, 8'd64, 8'd64, bad(1, 2'b10));
    settle(200);
    check("t5_timeout_at", 64'(t_rsp - t_in), 64'(TO + 1));
    check("t5_drained", 64'(n_out - b_out), 64'(1));
    check("t5_idle", 64'(busy), 64'(0));
    core_lat = 4;
    job(0, 8'd100, 8'd90, good(0, 8'd100, 8'd90));
    settle(100);
    // backpressure on both core input and response
    core_lat = 6;
    in_stall = 5;
    rsp_hold = 4;
    b_in = n_in;
    b_civ = n_civ;
    b_rv = n_rv;
    b_rsp = n_rsp;
    job(1, 8'd77, 8'd33, good(1, 8'd77, 8'd33));
    settle(100);
    check("t6_in_xfers", 64'(n_in - b_in), 64'(1));
    check("t6_issue_cycles", 64'(n_civ - b_civ), 64'(6));
    check("t6_rsp_cycles", 64'(n_rv - b_rv), 64'(5));
    check("t6_rsp_xfers", 64'(n_rsp - b_rsp), 64'(1));
    // reset in the middle of a core run
    core_lat = 30;
    job(0, 8'd20, 8'd20, good(0, 8'd20, 8'd20));
    repeat (5) @(negedge clk);
    check("t7_busy_before", 64'(busy), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t7_busy", 64'(busy), 64'(0));
    check("t7_core_out_ready", 64'(core_out_ready), 64'(0));
    check("t7_core_in_valid", 64'(core_in_valid), 64'(0));
    check("t7_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t7_req_ready", 64'(req_ready), 64'(0));
    check("t7_core_ref_len", 64'(core_ref_len), 64'(0));
    check("t7_rsp_score", 64'(rsp_score), 64'(0));
    core_lat = 4;
    @(posedge clk);
    #1;
    load(0, 8'd50, 8'd60);
    load(1, 8'd70, 8'd80);
    sb_q.push_back(good(0, 8'd50, 8'd60));
    req_valid = '1;
    @(negedge clk);
    check("t7_rr_ptr_reset", 64'(req_ready), 64'(2'b01));
    @(posedge clk);
    #1 req_valid = '0;
    settle(100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
